ahblite_mst_arbiter: RTL

Multi-master front end for the single-master AHB-Lite interconnect: merges MST_NUM AHB-Lite masters (e.g. CPU I-bus, CPU D-bus, DMA) onto the one master port of `ahblite_interconnect`. Each upstream port behaves as an AHB-Lite slave; the downstream port is an AHB-Lite master. The current owner passes through with zero latency; other masters' address phases are captured and replayed later under round-robin arbitration. Bursts and locked sequences are never split.

---
 rtl/ahblite_pkg.sv | 36 +++
 rtl/ahblite_rr_arbiter.sv | 27 ++
 rtl/ahblite_mst_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the address-phase record used for
// capturing and muxing master requests.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Widest address the capture registers can hold.
  localparam int AHB_AW_MAX = 32;

  typedef struct packed {
    logic [AHB_AW_MAX-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } ahb_addr_ph_t;

  // BUSY and SEQ both mean the owner is mid-burst.
  function automatic logic trans_holds(input logic [1:0] trans);
    return (trans == HTRANS_BUSY) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahblite_rr_arbiter.sv
// Combinational round-robin grant: nearest requester after the owner wins,
// the owner itself is considered last, and hold pins the grant to the owner.
module ahblite_rr_arbiter #(
  parameter int  MST_NUM = 2,
  localparam int IW      = $clog2(MST_NUM)
) (
  input  logic [MST_NUM-1:0] req,
  input  logic [IW-1:0]      owner,
  input  logic               hold,
  output logic [IW-1:0]      grant
);

  logic [MST_NUM-1:0] rot;

  // rot[d] is the request of master (owner + 1 + d) mod MST_NUM.
  assign rot = MST_NUM'({req, req} >> ({1'b0, owner} + 1'b1));

  always_comb begin
    grant = owner;
    if (!hold) begin
      for (int d = MST_NUM - 1; d >= 0; d--) begin
        if (rot[d]) grant = IW'((int'(owner) + 1 + d) % MST_NUM);
      end
    end
  end

endmodule

// File: rtl/ahblite_mst_arbiter.sv
// Merges MST_NUM AHB-Lite masters onto one downstream master port. The owner
// passes through combinationally; other masters are captured and replayed.
module ahblite_mst_arbiter
  import ahblite_pkg::*;
#(
  parameter int AHB_AW  = 32,
  parameter int AHB_DW  = 32,
  parameter int MST_NUM = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MST_NUM-1:0]              hready_i,
  input  logic [MST_NUM-1:0][AHB_AW-1:0]  haddr_i,
  input  logic [MST_NUM-1:0]              hwrite_i,
  input  logic [MST_NUM-1:0][1:0]         htrans_i,
  input  logic [MST_NUM-1:0][2:0]         hsize_i,
  input  logic [MST_NUM-1:0][2:0]         hburst_i,
  input  logic [MST_NUM-1:0][3:0]         hprot_i,
  input  logic [MST_NUM-1:0]              hmastlock_i,
  input  logic [MST_NUM-1:0][AHB_DW-1:0]  hwdata_i,
  output logic [MST_NUM-1:0]              hreadyout_o,
  output logic [MST_NUM-1:0]              hresp_o,
  output logic [MST_NUM-1:0][AHB_DW-1:0]  hrdata_o,
  output logic                            m_hready_o,
  output logic [AHB_AW-1:0]               m_haddr_o,
  output logic                            m_hwrite_o,
  output logic [1:0]                      m_htrans_o,
  output logic [2:0]                      m_hsize_o,
  output logic [2:0]                      m_hburst_o,
  output logic [3:0]                      m_hprot_o,
  output logic                            m_hmastlock_o,
  output logic [AHB_DW-1:0]               m_hwdata_o,
  input  logic                            m_hreadyout_i,
  input  logic                            m_hresp_i,
  input  logic [AHB_DW-1:0]               m_hrdata_i
);

  localparam int IW = $clog2(MST_NUM);

  ahb_addr_ph_t              live [MST_NUM];
  ahb_addr_ph_t              pend [MST_NUM];
  ahb_addr_ph_t              src  [MST_NUM];
  logic [MST_NUM-1:0][1:0]   src_trans;
  logic [MST_NUM-1:0]        req;
  logic [MST_NUM-1:0]        pend_v;
  logic [IW-1:0]             owner;
  logic [IW-1:0]             grant;
  logic [IW-1:0]             dph_mst;
  logic                      dph_v;
  logic                      hold;
  logic                      accept;

  for (genvar i = 0; i < MST_NUM; i++) begin : g_port
    assign live[i] = '{addr:  AHB_AW_MAX'(haddr_i[i]),
                       write: hwrite_i[i],
                       size:  hsize_i[i],
                       burst: hburst_i[i],
                       prot:  hprot_i[i],
                       lock:  hmastlock_i[i]};

    // A captured transfer is always replayed as the start of a new sequence.
    assign src[i]       = pend_v[i] ? pend[i] : live[i];
    assign src_trans[i] = pend_v[i] ? HTRANS_NONSEQ : htrans_i[i];
    assign req[i]       = pend_v[i] | src_trans[i][1];

    assign hreadyout_o[i] = (dph_v && dph_mst == IW'(i)) ? m_hreadyout_i : ~pend_v[i];
    assign hresp_o[i]     = (dph_v && dph_mst == IW'(i)) ? m_hresp_i : 1'b0;
    assign hrdata_o[i]    = m_hrdata_i;
  end

  assign hold   = trans_holds(src_trans[owner]) | src[owner].lock;
  assign accept = m_hreadyout_i & req[grant];

  ahblite_rr_arbiter #(.MST_NUM(MST_NUM)) u_rr (
    .req   (req),
    .owner (owner),
    .hold  (hold),
    .grant (grant)
  );

  assign m_haddr_o     = AHB_AW'(src[grant].addr);
  assign m_hwrite_o    = src[grant].write;
  assign m_hsize_o     = src[grant].size;
  assign m_hburst_o    = src[grant].burst;
  assign m_hprot_o     = src[grant].prot;
  assign m_hmastlock_o = src[grant].lock;
  assign m_htrans_o    = (rst || !req[grant]) ? HTRANS_IDLE : src_trans[grant];
  assign m_hwdata_o    = hwdata_i[dph_mst];
  assign m_hready_o    = m_hreadyout_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= '0;
      dph_v   <= 1'b0;
      dph_mst <= '0;
      pend_v  <= '0;
      for (int i = 0; i < MST_NUM; i++) pend[i] <= '0;
    end else begin
      if (m_hreadyout_i) begin
        dph_v <= req[grant];
        if (req[grant]) begin
          owner   <= grant;
          dph_mst <= grant;
        end
      end
      // A master that loses arbitration while its bus is ready is parked here.
      for (int i = 0; i < MST_NUM; i++) begin
        if (accept && grant == IW'(i)) begin
          pend_v[i] <= 1'b0;
        end else if (htrans_i[i][1] && hready_i[i] && !pend_v[i]) begin
          pend_v[i] <= 1'b1;
          pend[i]   <= live[i];
        end
      end
    end
  end

endmodule
